// File: rtl/safe_code_programmer.sv
// -----------------------------------------------------------------------------
// safe_code_programmer
//
// Code-change controller for the digital safe. Holds the 5-bit unlock code and
// drives it to the combinational comparator. A new code is installed only after
// the current code is entered once and the new code twice. Repeated wrong
// authentications force a timed lockout. An idle entry sequence aborts after a
// timeout.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset
//   in_i        - code value, sampled on an enter_i cycle
//   enter_i     - one-cycle strobe submitting in_i
//   prog_req_i  - one-cycle strobe requesting a code change
//   code_o      - stored code
//   busy_o      - high whenever the controller is not idle
//   done_o      - one-cycle pulse when a new code is installed
//   err_o       - one-cycle pulse on failure or timeout
//   locked_o    - high during lockout
// -----------------------------------------------------------------------------
module safe_code_programmer #(
    parameter logic [4:0] DEFAULT_CODE = 5'b01100,
    parameter int         MAX_FAIL     = 3,
    parameter int         LOCK_CYCLES  = 16,
    parameter int         TIMEOUT      = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] in_i,
    input  logic       enter_i,
    input  logic       prog_req_i,
    output logic [4:0] code_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       locked_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AUTH,
        ST_NEW1,
        ST_NEW2,
        ST_LOCKOUT
    } state_e;

    // The timer only ever holds values up to max(TIMEOUT, LOCK_CYCLES) - 1.
    localparam int TMAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    MAX_FAIL_C   = 3'(MAX_FAIL);

    state_e        state_q, state_d;
    logic [4:0]    code_q, code_d;
    logic [4:0]    pending_q, pending_d;
    logic [2:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          locked_q, locked_d;

    logic [2:0]    fail_inc;

    assign fail_inc = fail_q + 3'd1;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        //       leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        code_d    = code_q;
        pending_d = pending_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A coincident enter is simply dropped; only prog_req matters.
                if (prog_req_i) begin
                    state_d = ST_AUTH;
                    timer_d = '0;
                end
            end

            ST_AUTH, ST_NEW1, ST_NEW2: begin
                timer_d = timer_q + 1'b1;
                // An enter on the terminal cycle wins over the timeout.
                if (enter_i) begin
                    timer_d = '0;
                    unique case (state_q)
                        ST_AUTH: begin
                            if (in_i == code_q) begin
                                state_d = ST_NEW1;
                                fail_d  = '0;
                            end else begin
                                fail_d  = fail_inc;
                                err_d   = 1'b1;
                                state_d = (fail_inc == MAX_FAIL_C) ? ST_LOCKOUT : ST_IDLE;
                            end
                        end
                        ST_NEW1: begin
                            pending_d = in_i;
                            state_d   = ST_NEW2;
                        end
                        default: begin  // ST_NEW2
                            // A confirm mismatch is not an auth failure: fail_q is untouched.
                            if (in_i == pending_q) begin
                                code_d = pending_q;
                                done_d = 1'b1;
                            end else begin
                                err_d  = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end
                    endcase
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end

            ST_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Status flags are derived from the next state so they change on the
        // same edge as the state itself.
        busy_d   = (state_d != ST_IDLE);
        locked_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register updating from the
        //       pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            code_q    <= DEFAULT_CODE;
            pending_q <= '0;
            fail_q    <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
        end
    end

    assign code_o   = code_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign locked_o = locked_q;

endmodule

// File: tb/tb_safe_code_programmer.sv
// -----------------------------------------------------------------------------
// tb_safe_code_programmer
//
// Directed testbench for safe_code_programmer. Inputs are driven with blocking
// assignments before a rising edge; outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_safe_code_programmer;

    logic       clk;
    logic       rst;
    logic [4:0] in_v;
    logic       enter;
    logic       prog_req;
    logic [4:0] code;
    logic       busy;
    logic       done;
    logic       err;
    logic       locked;

    int total = 0;
    int bad   = 0;

    safe_code_programmer #(
        .DEFAULT_CODE (5'b01100),
        .MAX_FAIL     (3),
        .LOCK_CYCLES  (16),
        .TIMEOUT      (64)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_i       (in_v),
        .enter_i    (enter),
        .prog_req_i (prog_req),
        .code_o     (code),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .locked_o   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given strobes; outputs are valid on return.
    task automatic step(input logic p, input logic e, input logic [4:0] v);
        prog_req = p;
        enter    = e;
        in_v     = v;
        @(posedge clk);
        #1;
        prog_req = 1'b0;
        enter    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_v     = '0;
        enter    = 1'b0;
        prog_req = 1'b0;

        // ---------------- reset ----------------
        do_reset();
        check("rst_code",   code,   5'b01100);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_err",    err,    1'b0);
        check("rst_locked", locked, 1'b0);

        // ---------------- successful change 01100 -> 10101 ----------------
        step(1'b1, 1'b0, 5'd0);
        check("chg_busy_rise", busy, 1'b1);
        step(1'b0, 1'b1, 5'b01100);
        check("chg_auth_err", err, 1'b0);
        step(1'b0, 1'b1, 5'b10101);
        check("chg_new1_busy", busy, 1'b1);
        check("chg_code_hold", code, 5'b01100);
        step(1'b0, 1'b1, 5'b10101);
        check("chg_done", done, 1'b1);
        check("chg_code", code, 5'b10101);
        check("chg_busy_fall", busy, 1'b0);
        idle(1);
        check("chg_done_1cyc", done, 1'b0);

        // New code authenticates; abort with a confirm mismatch.
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b10101);
        check("new_auth_ok_err", err, 1'b0);
        check("new_auth_ok_busy", busy, 1'b1);
        step(1'b0, 1'b1, 5'b01100);
        step(1'b0, 1'b1, 5'b00000);
        check("new_abort_err", err, 1'b1);
        check("new_abort_code", code, 5'b10101);
        // Old code must now fail.
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b01100);
        check("old_code_err", err, 1'b1);
        check("old_code_busy", busy, 1'b0);

        // ---------------- confirm mismatch ----------------
        do_reset();
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b01100);
        step(1'b0, 1'b1, 5'b00011);
        step(1'b0, 1'b1, 5'b00111);
        check("cm_err",  err,  1'b1);
        check("cm_code", code, 5'b01100);
        check("cm_busy", busy, 1'b0);
        check("cm_done", done, 1'b0);
        // Two wrong AUTHs must not lock (mismatch did not touch fail_cnt).
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 5'd0);
            step(1'b0, 1'b1, 5'b11111);
            check("cm_wrong_err", err, 1'b1);
            check("cm_wrong_nolock", locked, 1'b0);
        end

        // ---------------- lockout ----------------
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b11111);
        check("lk_err", err, 1'b1);
        check("lk_locked", locked, 1'b1);
        check("lk_busy", busy, 1'b1);
        // Cycles 2..16 of the lockout: strobes are ignored, locked stays high.
        for (int k = 1; k < 16; k++) begin
            step(1'b1, 1'b1, 5'b01100);
            check("lk_hold", locked, 1'b1);
            check("lk_no_err", err, 1'b0);
        end
        step(1'b1, 1'b1, 5'b01100);
        check("lk_end_locked", locked, 1'b0);
        check("lk_end_busy", busy, 1'b0);
        idle(1);
        check("lk_preq_ignored", busy, 1'b0);
        // Correct sequence after lockout.
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b01100);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b10101);
        check("lk_after_done", done, 1'b1);
        check("lk_after_code", code, 5'b10101);
        // Lockout end cleared fail_cnt: one wrong AUTH does not lock.
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b11111);
        check("lk_cleared", locked, 1'b0);

        // ---------------- timeout ----------------
        step(1'b1, 1'b0, 5'd0);
        idle(63);
        check("to_63_err", err, 1'b0);
        check("to_63_busy", busy, 1'b1);
        idle(1);
        check("to_64_err", err, 1'b1);
        check("to_64_busy", busy, 1'b0);
        idle(1);
        check("to_err_1cyc", err, 1'b0);
        // Enter on the terminal cycle wins.
        step(1'b1, 1'b0, 5'd0);
        idle(63);
        step(1'b0, 1'b1, 5'b10101);
        check("to_enter_err", err, 1'b0);
        check("to_enter_busy", busy, 1'b1);
        step(1'b0, 1'b1, 5'b00001);
        step(1'b0, 1'b1, 5'b00001);
        check("to_enter_done", done, 1'b1);
        check("to_enter_code", code, 5'b00001);

        // ---------------- simultaneous prog_req + enter ----------------
        step(1'b1, 1'b1, 5'b00001);
        check("sim_busy", busy, 1'b1);
        step(1'b0, 1'b1, 5'b11111);   // still in AUTH: wrong code must err
        check("sim_auth_err", err, 1'b1);
        check("sim_auth_busy", busy, 1'b0);

        // ---------------- reset in NEW2 ----------------
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b00001);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b10101);
        check("rn_code_set", code, 5'b10101);
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b00110);   // now in NEW2
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rn_code", code, 5'b01100);
        check("rn_busy", busy, 1'b0);
        check("rn_done", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/safe_code_programmer.md
# safe_code_programmer

Sequential code-change controller for the digital safe. It holds the 5-bit unlock code in a register and drives it into the combinational code comparator. A new code is installed only after the user enters the current code once and the new code twice. Repeated wrong authentications force a timed lockout, and an idle entry sequence is abandoned after a timeout.

## Interface
Parameters:
- `DEFAULT_CODE`, 5'b01100 — code loaded on reset.
- `MAX_FAIL`, 3 — consecutive failed authentications that trigger lockout (1..7).
- `LOCK_CYCLES`, 16 — lockout duration in clock cycles (≥1).
- `TIMEOUT`, 64 — cycles without `enter` before an open sequence aborts (≥2).

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `in` in 5 — code value, sampled only on an `enter` cycle.
- `enter` in 1 — one-cycle strobe that submits `in`.
- `prog_req` in 1 — one-cycle strobe that requests a code change.
- `code` out 5 — stored code, fed to the comparator.
- `busy` out 1 — high whenever the state is not IDLE.
- `done` out 1 — one-cycle pulse when a new code is installed.
- `err` out 1 — one-cycle pulse on failure or timeout.
- `locked` out 1 — high during LOCKOUT.

## Operation
States: IDLE, AUTH, NEW1, NEW2, LOCKOUT.

Internal registers:
- `pending[4:0]` — first copy of the new code.
- `fail_cnt` — 3 bits.
- `timer` — wide enough for max(`TIMEOUT`, `LOCK_CYCLES`).

Transitions:
- **IDLE:**
  - `prog_req` → AUTH; `timer` cleared.
  - `enter` is ignored.
  - If `prog_req` and `enter` arrive together: go to AUTH and discard that `enter`.
- **AUTH, on `enter`:**
  - `in == code` → NEW1; `fail_cnt` cleared.
  - `in != code` → `fail_cnt + 1`, `err` pulse.
    - If the incremented `fail_cnt == MAX_FAIL`: go to LOCKOUT.
    - Otherwise: go to IDLE.
- **NEW1, on `enter`:** `pending` ← `in`; go to NEW2.
- **NEW2, on `enter`:**
  - `in == pending` → `code` ← `pending`, `done` pulse, go to IDLE.
  - Mismatch → `err` pulse, go to IDLE; `code` unchanged; `fail_cnt` unchanged.
- **Timeout (AUTH, NEW1, NEW2):**
  - `timer` increments every cycle and is cleared on each accepted `enter` and on entry to the state.
  - When `timer` reaches `TIMEOUT-1` with no `enter`: `err` pulse, go to IDLE.
  - Timeout does not count as a failed authentication.
  - `enter` on the terminal cycle takes priority over the timeout.
- **LOCKOUT:**
  - `locked` = 1; `prog_req` and `enter` are ignored.
  - `timer` counts `LOCK_CYCLES` cycles, then go to IDLE with `fail_cnt` cleared.
- `prog_req` outside IDLE is ignored; it does not restart the sequence.
- A successful `done` does not clear `fail_cnt`; only a successful AUTH or the end of a lockout clears it.
- Every code comparison is a full 5-bit equality. No partial matching.

## Timing
- **Reset values** (the cycle after `rst` is sampled high):
  - `code` = `DEFAULT_CODE`; state = IDLE.
  - `fail_cnt` = 0, `timer` = 0, `pending` = 0.
  - `busy` = 0, `done` = 0, `err` = 0, `locked` = 0.
- **Reset mid-sequence:** any state returns to IDLE and `code` reverts to `DEFAULT_CODE`. A reset during LOCKOUT ends the lockout immediately.
- **Output registration:** all outputs are registered. `done` and `err` go high on the edge that samples the causing `enter` or timeout, and stay high for exactly one cycle.
- **Code update timing:** `code` changes on the same edge that raises `done`. The comparator sees the new code from that cycle onward.
- **`busy`:** rises on the edge that samples `prog_req` in IDLE. It falls on the edge that returns the state to IDLE, which is the same edge as `done`/`err`.
- **`locked`:** rises on the edge that enters LOCKOUT and stays high for exactly `LOCK_CYCLES` cycles.
- **Minimum sequence:** a full change takes 4 strobes (`prog_req`, `enter`×3) with no required gap. Back-to-back `enter` strobes on consecutive cycles are legal.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `code` = 01100; `busy`, `done`, `err`, `locked` = 0.
- **Successful change:** `prog_req`, then `enter` with `in` = 01100, then 10101, then 10101 → `done` pulses 1 cycle, `code` = 10101, `busy` falls with `done`. A later change must authenticate with 10101, and 01100 must then fail.
- **Confirm mismatch:** `prog_req`, then `enter` with 01100, 00011, 00111 → `err` pulse; `code` stays 01100; `fail_cnt` unchanged (verify that 2 further wrong AUTHs do not lock).
- **Lockout:** 3 sequences with a wrong AUTH (`in` = 11111) → `err` pulses on each. After the 3rd, `locked` = 1 for 16 cycles and `prog_req` is ignored throughout. After the lockout, a correct sequence succeeds.
- **Timeout:** `prog_req`, then no `enter` for 64 cycles → `err` pulses at cycle 64 and state returns to IDLE. Repeat with `enter` (correct code) on cycle 64 → goes to NEW1 with no `err`.
- **Simultaneous events and reset:** `prog_req` and `enter` together in IDLE → AUTH, with that `enter` discarded. `rst` asserted in NEW2 after `code` was changed to 10101 → IDLE, `code` = 01100.
